// File: rtl/mod7_frame_serializer.sv
// Serializes WIDTH-bit words LSB-first into a free-running serial mod-7 accumulator
// and reports each word's residue as the difference of the accumulator residues around the frame.
module mod7_frame_serializer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_data,
    input  logic [2:0]       resid_in,
    output logic             res_valid,
    output logic [2:0]       res_data,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_RESULT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_phase;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_start;
    logic             r_ser;
    logic             r_res_valid;
    logic [2:0]       r_res_data;

    logic             w_accept;
    logic [2:0]       w_resid;
    logic [3:0]       w_diff;
    logic [2:0]       w_word_res;

    // Accepting only on phase 2 makes bit i land on phase i mod 3, i.e. weight 2^i mod 7.
    assign in_ready   = (r_state == S_IDLE) && (r_phase == 2'd2);
    assign w_accept   = in_valid && in_ready;

    // An out-of-range residue of 7 is congruent to 0.
    assign w_resid    = (resid_in == 3'd7) ? 3'd0 : resid_in;
    assign w_diff     = {1'b0, w_resid} + 4'd7 - {1'b0, r_start};
    assign w_word_res = (w_diff >= 4'd7) ? 3'(w_diff - 4'd7) : w_diff[2:0];

    assign ser_data   = r_ser;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign busy       = (r_state != S_IDLE);

    // NOTE: all state uses non-blocking assignments so every read in this block sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_phase     <= 2'd0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_start     <= 3'd0;
            r_ser       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= 3'd0;
        end else begin
            r_phase     <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            r_res_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ser   <= in_data[0];
                        r_shift <= in_data >> 1;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        r_start <= w_resid;
                    end
                    if (r_cnt == LAST_BIT) begin
                        r_ser   <= 1'b0;
                        r_state <= S_RESULT;
                    end else begin
                        r_ser   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    r_res_data  <= w_word_res;
                    r_res_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod7_frame_serializer.sv
// Bench for mod7_frame_serializer: two instances (WIDTH=16 and WIDTH=1), each driving a
// modelled serial mod-7 accumulator, checked every cycle against a frame-schedule model.
module tb_mod7_frame_serializer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  ser;
    logic [1:0]  rv;
    logic [1:0]  busy;
    logic [15:0] d0;
    logic [0:0]  d1;
    logic [2:0]  acc [2];
    logic [2:0]  rd  [2];

    int n_pass  = 0;
    int n_total = 0;

    // Model state: cycle index since reset, first bit cycle and word of the latest frame.
    int          cyc = 0;
    int          fb0 [2] = '{-100, -100};
    logic [63:0] fword [2];
    int          acc_log [2][$];
    int          res_log [2][$];

    mod7_frame_serializer #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(d0), .ser_data(ser[0]), .resid_in(acc[0]), .res_valid(rv[0]),
        .res_data(rd[0]), .busy(busy[0])
    );

    mod7_frame_serializer #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(d1), .ser_data(ser[1]), .resid_in(acc[1]), .res_valid(rv[1]),
        .res_data(rd[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wid(input int k);
        return (k == 0) ? 16 : 1;
    endfunction

    function automatic bit m_busy(input int k, input int c);
        return (c >= fb0[k]) && (c <= fb0[k] + wid(k));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Accumulator model plus accept tracking, both advancing on the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) fb0[k] = -100;
            acc[0] <= 3'd0;
            acc[1] <= 3'd0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int wt;
                wt = ser[k] ? (1 << (cyc % 3)) : 0;
                acc[k] <= 3'((int'(acc[k]) + wt) % 7);
                if (in_valid[k] && (cyc % 3 == 2) && !m_busy(k, cyc)) begin
                    fb0[k]   = cyc + 1;
                    fword[k] = (k == 0) ? 64'(d0) : 64'(d1);
                    acc_log[k].push_back(cyc);
                end
            end
            cyc++;
        end
    end

    // Per-cycle compare of both instances against the frame schedule.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int   c;
                int   b;
                int   w;
                logic e_ser;
                logic e_busy;
                logic e_rdy;
                logic e_rv;
                c      = cyc;
                b      = fb0[k];
                w      = wid(k);
                e_ser  = (c >= b && c < b + w) ? fword[k][c - b] : 1'b0;
                e_busy = m_busy(k, c);
                e_rdy  = (c % 3 == 2) && !e_busy;
                e_rv   = (c == b + w + 1);
                check($sformatf("k%0d_ser", k), ser[k], e_ser);
                check($sformatf("k%0d_busy", k), busy[k], e_busy);
                check($sformatf("k%0d_in_ready", k), in_ready[k], e_rdy);
                check($sformatf("k%0d_res_valid", k), rv[k], e_rv);
                if (e_rv) check($sformatf("k%0d_res_data", k), rd[k], fword[k] % 7);
                if (rv[k]) res_log[k].push_back(int'(rd[k]));
            end
        end
    end

    task automatic send(input int k, input logic [63:0] data);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        if (k == 0) d0 = data[15:0];
        else d1 = data[0:0];
        while (!in_ready[k] && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check($sformatf("k%0d_accept_timeout", k), in_ready[k], 1);
        @(negedge clk);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (cyc <= fb0[k] + wid(k) + 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check($sformatf("k%0d_done_timeout", k), busy[k], 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_k%0d_ser", tag, k), ser[k], 0);
            check($sformatf("%s_k%0d_res_valid", tag, k), rv[k], 0);
            check($sformatf("%s_k%0d_res_data", tag, k), rd[k], 0);
            check($sformatf("%s_k%0d_busy", tag, k), busy[k], 0);
            check($sformatf("%s_k%0d_in_ready", tag, k), in_ready[k], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [7:0] t1_bits;
        int         n;
        int         sz;
        t1_bits  = 8'h64;
        rst_n    = 1'b0;
        in_valid = 2'b00;
        d0       = '0;
        d1       = '0;

        // Word 100 with in_valid held from reset.
        in_valid[0] = 1'b1;
        d0 = 16'd100;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("reset");
        @(negedge clk);
        check("t1_ready_c1", in_ready[0], 0);
        @(negedge clk);
        check("t1_ready_c2", in_ready[0], 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t1_bit%0d", i), ser[0], t1_bits[i]);
            @(negedge clk);
        end
        n = 0;
        while (cyc < 20 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_res_valid", rv[0], 1);
        check("t1_res_data", rd[0], 2);

        // Back-to-back words 7, 0xFFFF, 0.
        send(0, 64'h7);
        send(0, 64'hFFFF);
        send(0, 64'h0);
        wait_done(0);
        sz = res_log[0].size();
        check("t2_res0", res_log[0][sz-3], 0);
        check("t2_res1", res_log[0][sz-2], 1);
        check("t2_res2", res_log[0][sz-1], 0);
        n = acc_log[0].size();
        check("t2_gap_a", acc_log[0][n-2] - acc_log[0][n-3], 18);
        check("t2_gap_b", acc_log[0][n-1] - acc_log[0][n-2], 18);

        // Words 6 and 6 exercise the wrap in the residue subtraction.
        send(0, 64'd6);
        send(0, 64'd6);
        wait_done(0);
        sz = res_log[0].size();
        check("t3_res0", res_log[0][sz-2], 6);
        check("t3_res1", res_log[0][sz-1], 6);

        // in_valid raised on a phase-0 idle cycle waits for phase 2.
        n = 0;
        while (!(cyc % 3 == 0 && cyc > fb0[0] + 16) && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid[0] = 1'b1;
        d0 = 16'($urandom);
        check("t4_ready_p0", in_ready[0], 0);
        check("t4_ser_p0", ser[0], 0);
        @(negedge clk);
        check("t4_ready_p1", in_ready[0], 0);
        check("t4_ser_p1", ser[0], 0);
        @(negedge clk);
        check("t4_ready_p2", in_ready[0], 1);
        check("t4_ser_p2", ser[0], 0);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_done(0);

        // Reset while the 8th bit of a frame is on the line; the frame must vanish.
        send(0, 64'($urandom) | 64'h1);
        n = 0;
        while (cyc < fb0[0] + 7 && n < 40) begin
            @(negedge clk);
            n++;
        end
        sz = res_log[0].size();
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send(0, 64'd13);
        wait_done(0);
        check("t5_log_size", res_log[0].size(), sz + 1);
        check("t5_res", res_log[0][res_log[0].size()-1], 6);

        // WIDTH=1 instance: words 1 then 0, accepted 3 cycles apart.
        send(1, 64'd1);
        send(1, 64'd0);
        wait_done(1);
        sz = res_log[1].size();
        check("t6_res0", res_log[1][sz-2], 1);
        check("t6_res1", res_log[1][sz-1], 0);
        n = acc_log[1].size();
        check("t6_gap", acc_log[1][n-1] - acc_log[1][n-2], 3);

        // Randomized traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            in_valid[0] = ($urandom_range(0, 3) != 0);
            in_valid[1] = ($urandom_range(0, 3) != 0);
            d0 = 16'($urandom);
            d1 = 1'($urandom);
            @(negedge clk);
        end
        in_valid = 2'b00;
        wait_done(0);
        wait_done(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
